papa_sync_fifo: RTL and testbench

Parametrised single-clock FIFO with valid/ready handshakes on both sides, a programmable almost-full flag, synchronous flush and a sticky high-watermark. It is the general-purpose buffering stage for the papa example hierarchy and is instantiated between producer and consumer submodules wherever rate decoupling or back-pressure absorption is needed.

---
 rtl/papa_sync_fifo_if.sv | 33 +++
 rtl/papa_sync_fifo.sv | 65 ++++++
 tb/tb_papa_sync_fifo.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/papa_sync_fifo_if.sv
// papa_sync_fifo_if: handshake, flush and status bundle for papa_sync_fifo.
// Ports (signals):
//   flush                         synchronous clear request (producer side)
//   in_valid/in_data/in_ready     write handshake
//   out_valid/out_data/out_ready  read handshake
//   count/afull/max_count         occupancy status from the FIFO
// Modports: master = environment driving the FIFO, slave = the FIFO itself.
interface papa_sync_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1
);
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [CNT_W-1:0]  count;
    logic              afull;
    logic [CNT_W-1:0]  max_count;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, afull, max_count
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, afull, max_count
    );
endinterface

// File: rtl/papa_sync_fifo.sv
// papa_sync_fifo: single-clock valid/ready FIFO with almost-full flag, flush and high-watermark.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  papa_sync_fifo_if.slave: flush, in_valid/in_data/in_ready,
//        out_valid/out_data/out_ready, count, afull, max_count
module papa_sync_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AFULL_TH = DEPTH - 2,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input logic           clk,
    input logic           rst,
    papa_sync_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  max_count_q, max_count_d;
    logic              full, empty, push, pop, wr_en;

    // Pointers carry one wrap bit above the index: equal means empty,
    // same index with opposite wrap bit means full.
    always_comb begin
        empty       = wr_ptr_q == rd_ptr_q;
        full        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        push        = bus.in_valid && !full;
        pop         = bus.out_ready && !empty;
        wr_en       = push && !bus.flush;
        wr_ptr_d    = bus.flush ? '0 : wr_ptr_q + CNT_W'(push);
        rd_ptr_d    = bus.flush ? '0 : rd_ptr_q + CNT_W'(pop);
        count_d     = bus.flush ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
        max_count_d = bus.flush ? '0 : (count_d > max_count_q ? count_d : max_count_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            max_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            max_count_q <= max_count_d;
        end
    end

    // Storage is deliberately left out of reset and flush; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= bus.in_data;
    end

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign bus.count     = count_q;
    assign bus.afull     = count_q >= CNT_W'(AFULL_TH);
    assign bus.max_count = max_count_q;
endmodule

// File: tb/tb_papa_sync_fifo.sv
// tb_papa_sync_fifo: table-driven, directed and randomized checks of papa_sync_fifo against a queue model.
module tb_papa_sync_fifo;
    localparam int DW = 8;
    localparam int DP = 16;
    localparam int TH = 14;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    papa_sync_fifo_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

    papa_sync_fifo #(.DATA_W(DW), .DEPTH(DP), .AFULL_TH(TH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        fl;
        logic        iv;
        logic [7:0]  id;
        logic        ordy;
        int          cnt;
        logic        ir;
        logic        ov;
        logic [7:0]  od;
        logic        af;
        int          mx;
    } vec_t;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] mq[$];
    int         mx = 0;
    bit         last_acc;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)", nm, $time, act, act, exp, exp);
        end
    endtask

    task automatic compare();
        chk("count", int'(bus.count), mq.size());
        chk("in_ready", int'(bus.in_ready), int'(mq.size() < DP));
        chk("out_valid", int'(bus.out_valid), int'(mq.size() > 0));
        chk("afull", int'(bus.afull), int'(mq.size() >= TH));
        chk("max_count", int'(bus.max_count), mx);
        if (mq.size() > 0) chk("out_data", int'(bus.out_data), int'(mq[0]));
    endtask

    // One clock cycle: drive inputs, advance the queue model, then compare after the edge.
    task automatic cyc(input logic fl, input logic iv, input logic [7:0] id, input logic ordy);
        bit pu, po;
        bus.flush = fl;
        bus.in_valid = iv;
        bus.in_data = id;
        bus.out_ready = ordy;
        pu = iv && mq.size() < DP;
        po = ordy && mq.size() > 0;
        last_acc = pu;
        if (fl) begin
            mq.delete();
            mx = 0;
        end else begin
            if (po) void'(mq.pop_front());
            if (pu) mq.push_back(id);
            if (mq.size() > mx) mx = mq.size();
        end
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        vec_t tv[$];
        logic hv, ordy, fl;
        logic [7:0] hd;
        bit held;
        int piv, pord;

        for (int i = 1; i <= 16; i++)
            tv.push_back('{1'b0, 1'b1, 8'(i), 1'b0, i, i < 16, 1'b1, 8'h01, i >= TH, i});
        tv.push_back('{1'b0, 1'b1, 8'h11, 1'b0, 16, 1'b0, 1'b1, 8'h01, 1'b1, 16});
        tv.push_back('{1'b0, 1'b1, 8'h11, 1'b1, 15, 1'b1, 1'b1, 8'h02, 1'b1, 16});
        tv.push_back('{1'b0, 1'b1, 8'h11, 1'b0, 16, 1'b0, 1'b1, 8'h02, 1'b1, 16});
        for (int k = 1; k <= 16; k++)
            tv.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 16 - k, 1'b1, k < 16, 8'(k + 2), (16 - k) >= TH, 16});

        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        #2 rst = 1'b1;
        #10;
        compare();
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (tv[i]) begin
            bus.flush = tv[i].fl;
            bus.in_valid = tv[i].iv;
            bus.in_data = tv[i].id;
            bus.out_ready = tv[i].ordy;
            @(posedge clk);
            #1;
            chk("tbl_count", int'(bus.count), tv[i].cnt);
            chk("tbl_in_ready", int'(bus.in_ready), int'(tv[i].ir));
            chk("tbl_out_valid", int'(bus.out_valid), int'(tv[i].ov));
            chk("tbl_afull", int'(bus.afull), int'(tv[i].af));
            chk("tbl_max_count", int'(bus.max_count), tv[i].mx);
            if (tv[i].ov) chk("tbl_out_data", int'(bus.out_data), int'(tv[i].od));
        end
        mq.delete();
        mx = 16;

        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 100; i++) begin
            cyc(1'b0, 1'b1, 8'($urandom), 1'b1);
            chk("stream_count", int'(bus.count), 5);
        end

        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'(8'hB0 + i), 1'b0);
        chk("pre_flush_count", int'(bus.count), 9);
        cyc(1'b1, 1'b1, 8'hEE, 1'b0);
        cyc(1'b0, 1'b1, 8'h3C, 1'b0);
        chk("post_flush_head", int'(bus.out_data), 8'h3C);

        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
        chk("pre_rst_count", int'(bus.count), 7);
        #2 rst = 1'b1;
        #1;
        mq.delete();
        mx = 0;
        compare();
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1'b0, 1'b1, 8'h5A, 1'b0);
        chk("post_rst_head", int'(bus.out_data), 8'h5A);

        held = 1'b0;
        hv = 1'b0;
        hd = '0;
        for (int i = 0; i < 600; i++) begin
            piv = (i / 80) % 3 == 0 ? 85 : ((i / 80) % 3 == 1 ? 30 : 70);
            pord = (i / 80) % 3 == 0 ? 25 : ((i / 80) % 3 == 1 ? 85 : 70);
            if (!held) begin
                hv = $urandom_range(99) < piv;
                hd = 8'($urandom);
            end
            ordy = $urandom_range(99) < pord;
            fl = $urandom_range(59) == 0;
            cyc(fl, hv, hd, ordy);
            held = hv && !last_acc;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
